// File: rtl/pip_window_reader.sv
// Display-side reader for the downscaled PiP frame buffer: generates buffer read
// coordinates from the raster, realigns returned pixels and composites them over the background.
module pip_window_reader #(
    parameter int unsigned DISP_W     = 640,
    parameter int unsigned DISP_H     = 480,
    parameter int unsigned WIN_W      = 200,
    parameter int unsigned WIN_H      = 150,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned BORDER     = 2,
    parameter logic [29:0] BORDER_RGB = {10'h3FF, 10'h3FF, 10'h000}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        disp_valid,
    input  logic [10:0] dx,
    input  logic [10:0] dy,
    input  logic [9:0]  bg_r,
    input  logic [9:0]  bg_g,
    input  logic [9:0]  bg_b,
    input  logic        pos_load,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    input  logic        pip_en,
    output logic        win_active,
    output logic [7:0]  win_x,
    output logic [7:0]  win_y,
    input  logic        buf_valid,
    input  logic [9:0]  buf_r,
    input  logic [9:0]  buf_g,
    input  logic [9:0]  buf_b,
    output logic        out_valid,
    output logic [9:0]  out_r,
    output logic [9:0]  out_g,
    output logic [9:0]  out_b
);

    localparam logic [11:0] WIN_W_C = 12'(WIN_W);
    localparam logic [11:0] WIN_H_C = 12'(WIN_H);
    localparam logic [11:0] BORD_C  = 12'(BORDER);
    localparam logic [10:0] MAX_X   = 11'(DISP_W - WIN_W);
    localparam logic [10:0] MAX_Y   = 11'(DISP_H - WIN_H);
    localparam logic [7:0]  WX_MAX  = 8'(WIN_W - 1);
    localparam logic [7:0]  WY_MAX  = 8'(WIN_H - 1);

    typedef struct packed {
        logic        win;
        logic        bord;
        logic        dv;
        logic [29:0] rgb;
    } stage_t;

    logic [10:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [10:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic        act_en_q, act_en_d;

    logic [11:0] px, py, x_lo, x_hi, y_lo, y_hi, bx_lo, bx_hi, by_lo, by_hi;
    logic        in_rect, in_ext, in_win_c, in_bord_c;

    logic [7:0]  cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    logic [7:0]  win_x_q, win_x_d, win_y_q, win_y_d;
    logic        line_hit_q, line_hit_d, dv_prev_q;

    stage_t      s1_q, s1_d;
    stage_t      dly_q [RD_LAT];
    stage_t      dl;
    logic        out_valid_q;
    logic [29:0] out_rgb_q, out_rgb_d;

    // Origin shadowing: frame_start moves the old pending value before a same-cycle load lands.
    always_comb begin
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        act_en_d = act_en_q;
        if (pos_load) begin
            pend_x_d = (pos_x > MAX_X) ? MAX_X : pos_x;
            pend_y_d = (pos_y > MAX_Y) ? MAX_Y : pos_y;
        end
        if (frame_start) begin
            act_x_d  = pend_x_q;
            act_y_d  = pend_y_q;
            act_en_d = pip_en;
        end
    end

    // Window and border-ring decode; the ring is clipped at 0 rather than wrapping.
    always_comb begin
        px    = {1'b0, dx};
        py    = {1'b0, dy};
        x_lo  = {1'b0, act_x_q};
        y_lo  = {1'b0, act_y_q};
        x_hi  = x_lo + WIN_W_C;
        y_hi  = y_lo + WIN_H_C;
        bx_lo = (x_lo >= BORD_C) ? x_lo - BORD_C : 12'd0;
        by_lo = (y_lo >= BORD_C) ? y_lo - BORD_C : 12'd0;
        bx_hi = x_hi + BORD_C;
        by_hi = y_hi + BORD_C;
        in_rect   = (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
        in_ext    = (px >= bx_lo) && (px < bx_hi) && (py >= by_lo) && (py < by_hi);
        in_win_c  = act_en_q && disp_valid && in_rect;
        in_bord_c = act_en_q && disp_valid && !in_rect && in_ext;
    end

    // Read coordinate counters; win_y advances at the end of any line that touched the window.
    always_comb begin
        cnt_x_d    = 8'd0;
        cnt_y_d    = cnt_y_q;
        line_hit_d = line_hit_q;
        win_x_d    = 8'd0;
        win_y_d    = 8'd0;
        if (in_win_c) begin
            win_x_d    = cnt_x_q;
            win_y_d    = cnt_y_q;
            cnt_x_d    = (cnt_x_q == WX_MAX) ? WX_MAX : cnt_x_q + 8'd1;
            line_hit_d = 1'b1;
        end
        if (dv_prev_q && !disp_valid) begin
            line_hit_d = 1'b0;
            if (line_hit_q && (cnt_y_q != WY_MAX)) begin
                cnt_y_d = cnt_y_q + 8'd1;
            end
        end
        if (frame_start) begin
            cnt_y_d    = 8'd0;
            line_hit_d = 1'b0;
        end
    end

    always_comb begin
        s1_d      = '0;
        s1_d.win  = in_win_c;
        s1_d.bord = in_bord_c;
        s1_d.dv   = disp_valid;
        s1_d.rgb  = {bg_r, bg_g, bg_b};
    end

    assign dl = dly_q[RD_LAT-1];

    // Composite priority: buffer pixel, border, background.
    always_comb begin
        out_rgb_d = 30'd0;
        if (dl.win && buf_valid) begin
            out_rgb_d = {buf_r, buf_g, buf_b};
        end else if (dl.win) begin
            out_rgb_d = dl.rgb;
        end else if (dl.bord) begin
            out_rgb_d = BORDER_RGB;
        end else if (dl.dv) begin
            out_rgb_d = dl.rgb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            act_x_q     <= '0;
            act_y_q     <= '0;
            act_en_q    <= 1'b0;
            cnt_x_q     <= '0;
            cnt_y_q     <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            line_hit_q  <= 1'b0;
            dv_prev_q   <= 1'b0;
            s1_q        <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                dly_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            act_en_q    <= act_en_d;
            cnt_x_q     <= cnt_x_d;
            cnt_y_q     <= cnt_y_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            line_hit_q  <= line_hit_d;
            dv_prev_q   <= disp_valid;
            s1_q        <= s1_d;
            dly_q[0]    <= s1_q;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
            out_valid_q <= dl.dv;
            out_rgb_q   <= out_rgb_d;
        end
    end

    assign win_active = s1_q.win;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign out_valid  = out_valid_q;
    assign out_r      = out_rgb_q[29:20];
    assign out_g      = out_rgb_q[19:10];
    assign out_b      = out_rgb_q[9:0];

endmodule

// File: tb/tb_pip_window_reader.sv
// Bench for pip_window_reader: sparse rasters, a 2-cycle buffer model, a per-cycle reference
// model built from coordinate subtraction, and a table of hand-computed spot values.
module tb_pip_window_reader;

    logic        clk;
    logic        rst_n;
    logic        frame_start, disp_valid, pos_load, pip_en;
    logic [10:0] dx, dy, pos_x, pos_y;
    logic [9:0]  bg_r, bg_g, bg_b;
    logic        win_active;
    logic [7:0]  win_x, win_y;
    logic        buf_valid;
    logic [9:0]  buf_r, buf_g, buf_b;
    logic        out_valid;
    logic [9:0]  out_r, out_g, out_b;

    pip_window_reader dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .disp_valid(disp_valid),
        .dx(dx), .dy(dy), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .pos_load(pos_load), .pos_x(pos_x), .pos_y(pos_y), .pip_en(pip_en),
        .win_active(win_active), .win_x(win_x), .win_y(win_y),
        .buf_valid(buf_valid), .buf_r(buf_r), .buf_g(buf_g), .buf_b(buf_b),
        .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: returns win_x as red, win_y as green two cycles after the request.
    logic       buf_on;
    logic       b1_v, b2_v;
    logic [7:0] b1_x, b2_x, b1_y, b2_y;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1_v <= 1'b0; b2_v <= 1'b0;
            b1_x <= 8'd0; b2_x <= 8'd0; b1_y <= 8'd0; b2_y <= 8'd0;
        end else begin
            b1_v <= win_active; b1_x <= win_x; b1_y <= win_y;
            b2_v <= b1_v;       b2_x <= b1_x;  b2_y <= b1_y;
        end
    end
    assign buf_valid = b2_v & buf_on;
    assign buf_r     = {2'b00, b2_x};
    assign buf_g     = {2'b00, b2_y};
    assign buf_b     = 10'h2AA;

    typedef struct {
        int          fid;
        int          x;
        int          y;
        logic        win;
        logic [7:0]  wx;
        logic [7:0]  wy;
        logic        ov;
        logic [29:0] rgb;
    } exp_t;

    typedef struct {
        int          fid;
        int          y;
        int          x;
        bit          cw;
        logic [16:0] win;
        bit          co;
        logic [29:0] rgb;
    } spot_t;

    localparam logic [29:0] BRGB = {10'h3FF, 10'h3FF, 10'h000};

    exp_t        hist[$];
    spot_t       spots[$];
    logic [16:0] cap_win [int];
    logic [29:0] cap_out [int];
    int n_chk, n_fail, win_cnt, cur_fid;
    int m_ax, m_ay, m_px, m_py;
    bit m_en;

    function automatic int key(input int f, input int y, input int x);
        return f * (1 << 22) + y * (1 << 11) + x;
    endfunction

    function automatic logic [29:0] bg_of(input logic v, input int x, input int y);
        if (v) return {10'(x), 10'(y), 10'h0F0};
        return {10'h2AB, 10'h155, 10'h0CC};
    endfunction

    // Reference: read coordinates by subtraction from the active origin.
    function automatic exp_t model(input logic v, input int x, input int y);
        exp_t e;
        bit inw, inb;
        logic [29:0] bg;
        bg  = bg_of(v, x, y);
        inw = m_en && v && x >= m_ax && x < m_ax + 200 && y >= m_ay && y < m_ay + 150;
        inb = m_en && v && !inw && x + 2 >= m_ax && x < m_ax + 202 && y + 2 >= m_ay && y < m_ay + 152;
        e.fid = cur_fid; e.x = x; e.y = y; e.win = inw;
        e.wx  = inw ? 8'(x - m_ax) : 8'd0;
        e.wy  = inw ? 8'(y - m_ay) : 8'd0;
        e.ov  = v;
        if (inw && buf_on)   e.rgb = {10'(x - m_ax), 10'(y - m_ay), 10'h2AA};
        else if (inw)        e.rgb = bg;
        else if (inb)        e.rgb = BRGB;
        else if (v)          e.rgb = bg;
        else                 e.rgb = 30'd0;
        return e;
    endfunction

    task automatic check_outputs();
        exp_t ew, eo;
        if (hist.size() >= 1) begin
            ew = hist[hist.size()-1];
            n_chk++;
            if ({win_active, win_x, win_y} !== {ew.win, ew.wx, ew.wy}) begin
                n_fail++;
                $display("FAIL win_rd fid=%0d y=%0d x=%0d got act=%0b x=%0d y=%0d want act=%0b x=%0d y=%0d",
                         ew.fid, ew.y, ew.x, win_active, win_x, win_y, ew.win, ew.wx, ew.wy);
            end
            if (ew.ov) cap_win[key(ew.fid, ew.y, ew.x)] = {win_active, win_x, win_y};
            if (ew.fid == 1 && win_active === 1'b1) win_cnt++;
        end
        if (hist.size() >= 4) begin
            eo = hist[hist.size()-4];
            n_chk++;
            if ({out_valid, out_r, out_g, out_b} !== {eo.ov, eo.rgb}) begin
                n_fail++;
                $display("FAIL out_px fid=%0d y=%0d x=%0d got v=%0b rgb=%h want v=%0b rgb=%h",
                         eo.fid, eo.y, eo.x, out_valid, {out_r, out_g, out_b}, eo.ov, eo.rgb);
            end
            if (eo.ov) cap_out[key(eo.fid, eo.y, eo.x)] = {out_r, out_g, out_b};
        end
    endtask

    // One cycle: check what the previous cycles produced, then drive this cycle at the negedge.
    task automatic tick(input logic v, input int x, input int y, input logic fs, input logic pl);
        check_outputs();
        disp_valid  = v;
        dx          = 11'(x);
        dy          = 11'(y);
        frame_start = fs;
        pos_load    = pl;
        {bg_r, bg_g, bg_b} = bg_of(v, x, y);
        hist.push_back(model(v, x, y));
        if (fs) begin m_ax = m_px; m_ay = m_py; m_en = pip_en; end
        if (pl) begin
            m_px = (int'(pos_x) > 440) ? 440 : int'(pos_x);
            m_py = (int'(pos_y) > 330) ? 330 : int'(pos_y);
        end
        if (hist.size() > 6) void'(hist.pop_front());
        @(negedge clk);
    endtask

    task automatic start_frame(input bit en, input bit ld, input int lx, input int ly);
        cur_fid++;
        pip_en = en;
        pos_x  = 11'(lx);
        pos_y  = 11'(ly);
        tick(1'b0, 0, 0, 1'b1, ld);
    endtask

    task automatic load(input int lx, input int ly);
        pos_x = 11'(lx);
        pos_y = 11'(ly);
        tick(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic line(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) tick(1'b1, x, y, 1'b0, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // act/r < 0 means that part of the spot is not checked.
    task automatic add(input int f, input int y, input int x, input int act, input int wx, input int wy,
                       input int r, input int g, input int b);
        spot_t s;
        s.fid = f; s.y = y; s.x = x;
        s.cw  = (act >= 0);
        s.win = {1'(act), 8'(wx), 8'(wy)};
        s.co  = (r >= 0);
        s.rgb = {10'(r), 10'(g), 10'(b)};
        spots.push_back(s);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; win_cnt = 0; cur_fid = 0;
        m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_en = 1'b0;
        rst_n = 1'b0; frame_start = 1'b0; disp_valid = 1'b0; pos_load = 1'b0; pip_en = 1'b0;
        dx = '0; dy = '0; pos_x = '0; pos_y = '0; bg_r = '0; bg_g = '0; bg_b = '0;
        buf_on = 1'b1;

        add(1, 0, 0, 1, 0, 0, 0, 0, 682);        add(1, 149, 199, 1, 199, 149, 199, 149, 682);
        add(1, 150, 0, 0, 0, 0, 1023, 1023, 0);  add(1, 10, 200, 0, 0, 0, 1023, 1023, 0);
        add(1, 10, 202, 0, 0, 0, 202, 10, 240);  add(1, 150, 202, -1, 0, 0, 202, 150, 240);
        add(1, 151, 201, -1, 0, 0, 1023, 1023, 0);
        add(2, 330, 440, 1, 0, 0, 0, 0, 682);    add(2, 479, 639, 1, 199, 149, 199, 149, 682);
        add(2, 330, 439, 0, 0, 0, 1023, 1023, 0); add(2, 328, 440, 0, 0, 0, 1023, 1023, 0);
        add(2, 479, 437, 0, 0, 0, 437, 479, 240);
        add(3, 100, 100, 1, 0, 0, 0, 0, 682);    add(3, 100, 299, 1, 199, 0, 199, 0, 682);
        add(3, 100, 98, 0, 0, 0, 1023, 1023, 0); add(3, 100, 99, 0, 0, 0, 1023, 1023, 0);
        add(3, 100, 300, 0, 0, 0, 1023, 1023, 0); add(3, 100, 301, 0, 0, 0, 1023, 1023, 0);
        add(3, 100, 302, 0, 0, 0, 302, 100, 240); add(3, 100, 97, 0, 0, 0, 97, 100, 240);
        add(3, 98, 150, -1, 0, 0, 1023, 1023, 0); add(3, 101, 150, 1, 50, 1, 50, 1, 682);
        add(3, 97, 150, 0, 0, 0, 150, 97, 240);
        add(4, 100, 150, 1, 50, 0, 150, 100, 240); add(4, 100, 99, -1, 0, 0, 1023, 1023, 0);
        add(4, 99, 150, -1, 0, 0, 1023, 1023, 0);
        add(5, 100, 150, 0, 0, 0, 150, 100, 240); add(5, 100, 99, -1, 0, 0, 99, 100, 240);
        add(6, 101, 100, 1, 0, 1, -1, 0, 0);     add(6, 101, 110, 1, 10, 1, -1, 0, 0);
        add(7, 20, 20, 0, 0, 0, -1, 0, 0);       add(7, 200, 300, 1, 0, 0, -1, 0, 0);
        add(7, 200, 304, 1, 4, 0, -1, 0, 0);     add(8, 20, 20, 1, 0, 0, -1, 0, 0);
        add(90, 21, 25, 0, 0, 0, 25, 21, 240);   add(10, 0, 3, 1, 3, 0, 3, 0, 682);

        @(negedge clk);
        n_chk++;
        if ({win_active, win_x, win_y, out_valid, out_r, out_g, out_b} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_state got %h want 0", {win_active, win_x, win_y, out_valid, out_r, out_g, out_b});
        end
        for (int i = 0; i < 4; i++) hist.push_back(model(1'b0, 0, 0));
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 0, 0, 1'b0, 1'b0);

        // Frame 1: origin (0,0)
        start_frame(1'b1, 1'b0, 0, 0);
        for (int y = 0; y <= 151; y++) line(y, 0, 202);
        // Frame 2: clamped origin (440,330)
        load(500, 400);
        start_frame(1'b1, 1'b0, 0, 0);
        for (int y = 328; y <= 479; y++) line(y, 436, 639);
        // Frame 3: origin (100,100) with buffer data and border
        load(100, 100);
        start_frame(1'b1, 1'b0, 0, 0);
        for (int y = 97; y <= 101; y++) line(y, 96, 303);
        // Frame 4: buffer holds no frame
        buf_on = 1'b0;
        start_frame(1'b1, 1'b0, 0, 0);
        for (int y = 98; y <= 100; y++) line(y, 96, 303);
        buf_on = 1'b1;
        // Frame 5: window disabled
        start_frame(1'b0, 1'b0, 0, 0);
        line(100, 96, 303);
        // Frame 6: mid-frame load keeps the current origin
        start_frame(1'b1, 1'b0, 0, 0);
        line(100, 96, 110);
        load(300, 200);
        line(101, 96, 110);
        // Frame 7: load coincident with frame_start applies one frame later
        start_frame(1'b1, 1'b1, 20, 20);
        line(20, 16, 24);
        line(200, 296, 304);
        // Frame 8
        start_frame(1'b1, 1'b0, 0, 0);
        line(20, 16, 24);
        // Frame 9: reset pulsed mid-window
        start_frame(1'b1, 1'b0, 0, 0);
        for (int x = 16; x <= 30; x++) tick(1'b1, x, 20, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({win_active, win_x, win_y, out_valid, out_r, out_g, out_b} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_async got %h want 0", {win_active, win_x, win_y, out_valid, out_r, out_g, out_b});
        end
        m_en = 1'b0; m_ax = 0; m_ay = 0; m_px = 0; m_py = 0;
        cur_fid = 90;
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back(model(1'b0, 0, 0));
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        line(21, 16, 40);
        // Frame 10: first frame_start after reset, origin back at (0,0)
        cur_fid = 9;
        start_frame(1'b1, 1'b0, 0, 0);
        line(0, 0, 5);
        for (int i = 0; i < 8; i++) tick(1'b0, 0, 0, 1'b0, 1'b0);

        n_chk++;
        if (win_cnt != 30000) begin
            n_fail++;
            $display("FAIL win_count got %0d want 30000", win_cnt);
        end

        foreach (spots[i]) begin
            int k;
            k = key(spots[i].fid, spots[i].y, spots[i].x);
            if (spots[i].cw) begin
                n_chk++;
                if (!cap_win.exists(k)) begin
                    n_fail++;
                    $display("FAIL spot_win fid=%0d y=%0d x=%0d got none want %h", spots[i].fid, spots[i].y, spots[i].x, spots[i].win);
                end else if (cap_win[k] !== spots[i].win) begin
                    n_fail++;
                    $display("FAIL spot_win fid=%0d y=%0d x=%0d got %h want %h", spots[i].fid, spots[i].y, spots[i].x, cap_win[k], spots[i].win);
                end
            end
            if (spots[i].co) begin
                n_chk++;
                if (!cap_out.exists(k)) begin
                    n_fail++;
                    $display("FAIL spot_out fid=%0d y=%0d x=%0d got none want %h", spots[i].fid, spots[i].y, spots[i].x, spots[i].rgb);
                end else if (cap_out[k] !== spots[i].rgb) begin
                    n_fail++;
                    $display("FAIL spot_out fid=%0d y=%0d x=%0d got %h want %h", spots[i].fid, spots[i].y, spots[i].x, cap_out[k], spots[i].rgb);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pip_window_reader.md
Name: pip_window_reader

Overview:
- Display-side reader for the 200x150 downscaled frame buffer. It is the counterpart of the buffer's write path.
- From the 640x480 display raster, it generates the buffer's read window coordinates (win_active/win_x/win_y) at a programmable picture-in-picture origin.
- It realigns the buffer's returned pixels with the delayed background video.
- It composites the final pixel stream as: buffer pixel, then window border, then background, in that priority.

Parameters:
- DISP_W, 640, display active width
- DISP_H, 480, display active height
- WIN_W, 200, window width (must match the buffer's destination width)
- WIN_H, 150, window height
- RD_LAT, 2, cycles from the win_* outputs to buf_valid/buf_rgb
- BORDER, 2, border thickness in pixels around the window (0 = no border)
- BORDER_RGB, 30'h3FF_3FF_000, 10/10/10 border colour

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse before the first active display pixel
- disp_valid  in  1  display active-pixel strobe
- dx  in  11  display x coordinate, valid while disp_valid
- dy  in  11  display y coordinate, valid while disp_valid
- bg_r  in  10  background red
- bg_g  in  10  background green
- bg_b  in  10  background blue
- pos_load  in  1  capture pos_x/pos_y into the pending origin
- pos_x  in  11  requested window origin x
- pos_y  in  11  requested window origin y
- pip_en  in  1  window enable; sampled at frame_start
- win_active  out  1  read request to the buffer
- win_x  out  8  buffer read x, 0..WIN_W-1
- win_y  out  8  buffer read y, 0..WIN_H-1
- buf_valid  in  1  buffer data valid
- buf_r  in  10  buffer red
- buf_g  in  10  buffer green
- buf_b  in  10  buffer blue
- out_valid  out  1  composited pixel valid
- out_r  out  10  composited red
- out_g  out  10  composited green
- out_b  out  10  composited blue

Behaviour:
- Reset values: all outputs 0. Pending origin = active origin = (0,0). Active enable = 0. All pipeline stages cleared.
- Origin shadowing:
  - pos_load registers the clamped origin into pending: x = min(pos_x, DISP_W-WIN_W), y = min(pos_y, DISP_H-WIN_H).
  - On frame_start, pending -> active and pip_en -> active enable. Changes never take effect mid-frame.
  - If pos_load and frame_start occur in the same cycle, frame_start transfers the old pending value; the new value lands in pending and applies at the next frame.
- Stage 0 decode, registered into stage 1:
  - in_win = active enable & disp_valid & ax <= dx < ax+WIN_W & ay <= dy < ay+WIN_H.
  - in_bord = active enable & disp_valid & !in_win & pixel inside the window rectangle expanded by BORDER on each side. The expanded rectangle is clipped to the display with no wrap: a window at x=0 has no left border.
- Read coordinates come from counters; no subtraction from dx/dy.
  - win_x resets to 0 on any cycle with !in_win. It increments after each in_win pixel and saturates at WIN_W-1.
  - win_y resets to 0 at frame_start.
  - win_y increments on the disp_valid falling edge if the just-finished line contained at least one in_win pixel. It saturates at WIN_H-1.
  - win_active = registered in_win. win_x/win_y are registered alongside it, so all three change together 1 cycle after disp_valid/dx/dy.
  - When win_active=0, win_x/win_y are driven to 0.
- Alignment: the in_win, in_bord, disp_valid and bg_rgb flags/data are delayed by RD_LAT via a shift pipeline, so they meet buf_* coincidentally.
- Composite, registered:
  - delayed in_win & buf_valid -> buf_rgb.
  - delayed in_win & !buf_valid (buffer holds no frame yet) -> bg_rgb.
  - delayed in_bord -> BORDER_RGB.
  - delayed disp_valid -> bg_rgb.
  - otherwise -> 0.
- out_valid = delayed disp_valid.
- Total latency from disp_valid to out_valid/out_rgb is RD_LAT+2 cycles (4 at default), constant, and independent of window state.
- frame_start mid-line resets win_y but does not flush the pipeline.
- rst_n asserted mid-frame clears everything immediately. After release, the window is off until a frame_start with pip_en=1.

Test Plan:
- Reset release, pip_en=1 latched at frame_start, origin (0,0), 640x480 raster -> win_active high for dx 0..199 on dy 0..149 only. win_x ramps 0..199 per line; win_y ramps 0..149; 30000 window pixels per frame.
- pos_load (500,400) -> clamped to (440,330). The first win_active occurs with dx=440, dy=330, and win_x=0, win_y=0 on that cycle. The last read is (199,149) at dx=639, dy=479.
- pos_load issued mid-frame -> the current frame keeps the old origin and the next frame uses the new one. pos_load coincident with frame_start -> the new origin applies one frame later.
- Buffer model with RD_LAT=2 returning win_x as the red value, origin (100,100), BORDER=2 -> out_r at dx=100 equals 0 and at dx=299 equals 199. Pixels dx 98..99 and 300..301 on window rows are BORDER_RGB. Output latency is 4 cycles.
- buf_valid held 0 -> the window region shows bg_rgb while the border is still drawn. pip_en=0 at frame_start -> win_active is never asserted and out_rgb == bg_rgb delayed 4 cycles.
- rst_n pulsed mid-window -> all outputs 0 next cycle. After release, no win_active until the next frame_start with pip_en=1.
